clk_div_monitor: RTL and testbench

//   Checks a divided clock: samples clk_in in the clk domain and measures

---
 rtl/clk_mon_pkg.sv | 12 +
 rtl/clk_edge_sync.sv | 33 +++
 rtl/clk_div_monitor.sv | 197 +++++++++++++++++++
 tb/tb_clk_div_monitor.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_mon_pkg.sv
// Shared types and defaults for the divided-clock monitor.
package clk_mon_pkg;

    localparam int unsigned DEF_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        MEAS = 2'd2
    } mon_state_t;

endpackage

// File: rtl/clk_edge_sync.sv
// Brings the clock under test into the clk domain and flags its sampled
// rising and falling edges.
module clk_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic rise_o,
    output logic fall_o
);

    logic s1_q;
    logic s2_q;
    logic s3_q;

    // NOTE: non-blocking assignments make every stage take the previous
    // stage's old value, so this really is a three-deep shift chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= sig_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // s1 may go metastable; only s2 and its history s3 are used.
    assign rise_o = s2_q & ~s3_q;
    assign fall_o = ~s2_q & s3_q;

endmodule

// File: rtl/clk_div_monitor.sv
// Measures period and high time of a divided clock in clk cycles, flags
// tolerance violations and missing edges, and declares lock.
module clk_div_monitor
    import clk_mon_pkg::*;
#(
    parameter int unsigned CNT_W      = DEF_CNT_W,
    parameter int unsigned EXP_PERIOD = 5,
    parameter int unsigned PERIOD_TOL = 0,
    parameter int unsigned EXP_HIGH   = 2,
    parameter int unsigned HIGH_TOL   = 1,
    parameter int unsigned LOCK_CNT   = 4,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clk_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             period_err,
    output logic             duty_err,
    output logic             locked,
    output logic             timeout
);

    localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);

    localparam logic [CNT_W-1:0]        CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0]        CNT_MAX      = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]        TIMEOUT_C    = CNT_W'(TIMEOUT);
    localparam logic [GOOD_W-1:0]       GOOD_ONE     = GOOD_W'(1);
    localparam logic [GOOD_W-1:0]       LOCK_C       = GOOD_W'(LOCK_CNT);
    localparam logic signed [CNT_W:0]   EXP_PERIOD_S = (CNT_W+1)'(EXP_PERIOD);
    localparam logic signed [CNT_W:0]   EXP_HIGH_S   = (CNT_W+1)'(EXP_HIGH);
    localparam logic signed [CNT_W:0]   PER_TOL_P    = (CNT_W+1)'(PERIOD_TOL);
    localparam logic signed [CNT_W:0]   PER_TOL_N    = -PER_TOL_P;
    localparam logic signed [CNT_W:0]   HIGH_TOL_P   = (CNT_W+1)'(HIGH_TOL);
    localparam logic signed [CNT_W:0]   HIGH_TOL_N   = -HIGH_TOL_P;

    logic rise;
    logic fall;

    clk_edge_sync u_sync (
        .clk    (clk),
        .rst    (rst),
        .sig_i  (clk_in),
        .rise_o (rise),
        .fall_o (fall)
    );

    mon_state_t        state_q,      state_d;
    logic [CNT_W-1:0]  cnt_q,        cnt_d;
    logic [CNT_W-1:0]  period_q,     period_d;
    logic [CNT_W-1:0]  high_q,       high_d;
    logic [CNT_W-1:0]  high_r_q,     high_r_d;
    logic              fall_seen_q,  fall_seen_d;
    logic              meas_valid_q, meas_valid_d;
    logic              period_err_q, period_err_d;
    logic              duty_err_q,   duty_err_d;
    logic [GOOD_W-1:0] good_cnt_q,   good_cnt_d;
    logic              locked_q,     locked_d;
    logic              timeout_q,    timeout_d;

    logic [CNT_W-1:0]      cnt_inc;
    logic [CNT_W-1:0]      meas_high;
    logic signed [CNT_W:0] period_diff;
    logic signed [CNT_W:0] high_diff;
    logic                  period_bad;
    logic                  high_bad;

    assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
    // Without a fall in this period the whole period counts as high time.
    assign meas_high = fall_seen_q ? high_r_q : cnt_q;

    // One extra bit keeps the signed differences free of wrap-around.
    assign period_diff = $signed({1'b0, cnt_q}) - EXP_PERIOD_S;
    assign high_diff   = $signed({1'b0, meas_high}) - EXP_HIGH_S;

    assign period_bad = (period_diff > PER_TOL_P) || (period_diff < PER_TOL_N)
                        || (cnt_q == CNT_MAX);
    assign high_bad   = !fall_seen_q || (high_diff > HIGH_TOL_P) || (high_diff < HIGH_TOL_N);

    always_comb begin
        // NOTE: every variable gets a default before any branch so that no
        // path leaves it unassigned, which would infer a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        period_d     = period_q;
        high_d       = high_q;
        high_r_d     = high_r_q;
        fall_seen_d  = fall_seen_q;
        meas_valid_d = 1'b0;
        period_err_d = period_err_q;
        duty_err_d   = duty_err_q;
        good_cnt_d   = good_cnt_q;
        locked_d     = locked_q;
        timeout_d    = timeout_q;

        if (!en) begin
            state_d      = IDLE;
            fall_seen_d  = 1'b0;
            period_err_d = 1'b0;
            duty_err_d   = 1'b0;
            good_cnt_d   = '0;
            locked_d     = 1'b0;
            timeout_d    = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    // Start the arm window from zero, not from a stale count.
                    state_d = ARM;
                    cnt_d   = '0;
                end
                ARM: begin
                    cnt_d = rise ? CNT_ONE : cnt_inc;
                    if (rise) begin
                        state_d     = MEAS;
                        fall_seen_d = 1'b0;
                        timeout_d   = 1'b0;
                    end else if (cnt_q >= TIMEOUT_C) begin
                        timeout_d = 1'b1;
                    end
                end
                MEAS: begin
                    cnt_d = rise ? CNT_ONE : cnt_inc;
                    if (rise) begin
                        period_d     = cnt_q;
                        high_d       = meas_high;
                        meas_valid_d = 1'b1;
                        period_err_d = period_bad;
                        duty_err_d   = high_bad;
                        fall_seen_d  = 1'b0;
                        timeout_d    = 1'b0;
                        if (period_bad || high_bad) begin
                            good_cnt_d = '0;
                        end else if (good_cnt_q != LOCK_C) begin
                            good_cnt_d = good_cnt_q + GOOD_ONE;
                        end
                        locked_d = (good_cnt_d == LOCK_C);
                    end else begin
                        if (fall) begin
                            high_r_d    = cnt_q;
                            fall_seen_d = 1'b1;
                        end
                        if (cnt_q >= TIMEOUT_C) begin
                            state_d    = ARM;
                            timeout_d  = 1'b1;
                            locked_d   = 1'b0;
                            good_cnt_d = '0;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            period_q     <= '0;
            high_q       <= '0;
            high_r_q     <= '0;
            fall_seen_q  <= 1'b0;
            meas_valid_q <= 1'b0;
            period_err_q <= 1'b0;
            duty_err_q   <= 1'b0;
            good_cnt_q   <= '0;
            locked_q     <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            period_q     <= period_d;
            high_q       <= high_d;
            high_r_q     <= high_r_d;
            fall_seen_q  <= fall_seen_d;
            meas_valid_q <= meas_valid_d;
            period_err_q <= period_err_d;
            duty_err_q   <= duty_err_d;
            good_cnt_q   <= good_cnt_d;
            locked_q     <= locked_d;
            timeout_q    <= timeout_d;
        end
    end

    assign period     = period_q;
    assign high_time  = high_q;
    assign meas_valid = meas_valid_q;
    assign period_err = period_err_q;
    assign duty_err   = duty_err_q;
    assign locked     = locked_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed bench for clk_div_monitor: lock, period stretch, timeout, duty
// error, asynchronous reset and enable drop.
module tb_clk_div_monitor;
    import clk_mon_pkg::*;

    // Field order: period, high time, period_err, duty_err, locked.
    typedef struct packed {
        logic [7:0] period;
        logic [7:0] high;
        logic       perr;
        logic       derr;
        logic       lock;
    } meas_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       clk_in;
    logic [7:0] period;
    logic [7:0] high_time;
    logic       meas_valid;
    logic       period_err;
    logic       duty_err;
    logic       locked;
    logic       timeout;

    int    vec_cnt  = 0;
    int    miss_cnt = 0;
    meas_t mq[$];
    int    locked_cycles = 0;

    clk_div_monitor #(
        .CNT_W      (8),
        .EXP_PERIOD (5),
        .PERIOD_TOL (0),
        .EXP_HIGH   (2),
        .HIGH_TOL   (1),
        .LOCK_CNT   (4),
        .TIMEOUT    (64)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .clk_in     (clk_in),
        .period     (period),
        .high_time  (high_time),
        .meas_valid (meas_valid),
        .period_err (period_err),
        .duty_err   (duty_err),
        .locked     (locked),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    // Record every measurement, sampled half a cycle after the update edge.
    always @(negedge clk) begin
        if (meas_valid === 1'b1) mq.push_back(meas_t'{period, high_time, period_err, duty_err, locked});
        if (locked === 1'b1) locked_cycles++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    function automatic meas_t mk(input int p, input int h, input bit pe, input bit de, input bit lk);
        mk = '{period: 8'(p), high: 8'(h), perr: pe, derr: de, lock: lk};
    endfunction

    // Called 3 ns after a posedge; clk_in rises now, stays high for hi
    // samples, then low for lo samples, and returns 3 ns after a posedge.
    task automatic drive_cycle(input int hi, input int lo);
        clk_in = 1'b1;
        repeat (hi) @(posedge clk);
        #3 clk_in = 1'b0;
        repeat (lo) @(posedge clk);
        #3;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; clk_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vec_cnt++;
        if ({period, high_time, meas_valid, period_err, duty_err, locked, timeout} !== 21'd0) begin
            miss_cnt++;
            $display("FAIL reset_outputs: got p=%0d h=%0d mv=%b pe=%b de=%b lk=%b to=%b, expected all 0",
                     period, high_time, meas_valid, period_err, duty_err, locked, timeout);
        end
        #2 rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        vec_cnt++;
        if (dut.state_q !== IDLE) begin
            miss_cnt++;
            $display("FAIL reset_idle_state: got %0d, expected %0d", dut.state_q, IDLE);
        end
        vec_cnt++;
        if ({meas_valid, locked, timeout} !== 3'b000) begin
            miss_cnt++;
            $display("FAIL reset_en_low_status: got mv/lk/to=%b, expected 000", {meas_valid, locked, timeout});
        end
        #2;
    endtask

    // Divide-by-5 with sampled high time alternating 2/3.
    task automatic test_lock_acquire();
        int base;
        meas_t got;
        meas_t exp_q[$];
        base = mq.size();
        en = 1'b1;
        for (int k = 0; k < 5; k++) drive_cycle((k % 2 == 0) ? 2 : 3, (k % 2 == 0) ? 3 : 2);
        exp_q = '{mk(5, 2, 0, 0, 0), mk(5, 3, 0, 0, 0), mk(5, 2, 0, 0, 0), mk(5, 3, 0, 0, 1)};
        vec_cnt++;
        if (mq.size() - base !== exp_q.size()) begin
            miss_cnt++;
            $display("FAIL lock_acquire_count: got %0d, expected %0d", mq.size() - base, exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (base + i < mq.size()) ? mq[base + i] : '0;
            vec_cnt++;
            if (got !== exp_q[i]) begin
                miss_cnt++;
                $display("FAIL lock_acquire_meas%0d: got %p, expected %p", i, got, exp_q[i]);
            end
        end
    endtask

    task automatic test_period_stretch();
        int base;
        meas_t got;
        meas_t exp_q[$];
        base = mq.size();
        drive_cycle(3, 4);
        for (int k = 0; k < 5; k++) drive_cycle((k % 2 == 0) ? 2 : 3, (k % 2 == 0) ? 3 : 2);
        exp_q = '{mk(5, 2, 0, 0, 1), mk(7, 3, 1, 0, 0), mk(5, 2, 0, 0, 0),
                  mk(5, 3, 0, 0, 0), mk(5, 2, 0, 0, 0), mk(5, 3, 0, 0, 1)};
        vec_cnt++;
        if (mq.size() - base !== exp_q.size()) begin
            miss_cnt++;
            $display("FAIL stretch_count: got %0d, expected %0d", mq.size() - base, exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (base + i < mq.size()) ? mq[base + i] : '0;
            vec_cnt++;
            if (got !== exp_q[i]) begin
                miss_cnt++;
                $display("FAIL stretch_meas%0d: got %p, expected %p", i, got, exp_q[i]);
            end
        end
    endtask

    task automatic test_timeout();
        int base;
        int waited;
        meas_t got;
        base = mq.size();
        waited = 0;
        while (timeout !== 1'b1 && waited < 120) begin
            @(negedge clk);
            waited++;
        end
        vec_cnt++;
        if (timeout !== 1'b1) begin
            miss_cnt++;
            $display("FAIL timeout_assert: got %b after %0d cycles, expected 1", timeout, waited);
        end
        vec_cnt++;
        if (locked !== 1'b0) begin
            miss_cnt++;
            $display("FAIL timeout_unlock: got %b, expected 0", locked);
        end
        repeat (10) @(posedge clk);
        #3;
        vec_cnt++;
        if (dut.state_q !== ARM || timeout !== 1'b1) begin
            miss_cnt++;
            $display("FAIL timeout_sticky_arm: got state=%0d to=%b, expected state=%0d to=1",
                     dut.state_q, timeout, ARM);
        end
        drive_cycle(2, 3);
        vec_cnt++;
        if (timeout !== 1'b0 || mq.size() !== base) begin
            miss_cnt++;
            $display("FAIL timeout_clear_on_rise: got to=%b meas=%0d, expected to=0 meas=0",
                     timeout, mq.size() - base);
        end
        drive_cycle(2, 3);
        got = (mq.size() > base) ? mq[base] : '0;
        vec_cnt++;
        if (mq.size() - base !== 1 || got !== mk(5, 2, 0, 0, 0)) begin
            miss_cnt++;
            $display("FAIL timeout_first_meas: got count=%0d %p, expected count=1 %p",
                     mq.size() - base, got, mk(5, 2, 0, 0, 0));
        end
    endtask

    task automatic test_duty_error();
        int base;
        int lk_base;
        meas_t got;
        meas_t exp_q[$];
        base = mq.size();
        lk_base = locked_cycles;
        repeat (6) drive_cycle(4, 1);
        exp_q = '{mk(5, 2, 0, 0, 0), mk(5, 4, 0, 1, 0), mk(5, 4, 0, 1, 0),
                  mk(5, 4, 0, 1, 0), mk(5, 4, 0, 1, 0), mk(5, 4, 0, 1, 0)};
        vec_cnt++;
        if (mq.size() - base !== exp_q.size()) begin
            miss_cnt++;
            $display("FAIL duty_count: got %0d, expected %0d", mq.size() - base, exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (base + i < mq.size()) ? mq[base + i] : '0;
            vec_cnt++;
            if (got !== exp_q[i]) begin
                miss_cnt++;
                $display("FAIL duty_meas%0d: got %p, expected %p", i, got, exp_q[i]);
            end
        end
        vec_cnt++;
        if (locked_cycles !== lk_base) begin
            miss_cnt++;
            $display("FAIL duty_never_locked: got %0d locked cycles, expected 0", locked_cycles - lk_base);
        end
    endtask

    task automatic test_reset_mid_meas();
        int base;
        meas_t got;
        clk_in = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        vec_cnt++;
        if ({period, high_time, meas_valid, period_err, duty_err, locked, timeout} !== 21'd0) begin
            miss_cnt++;
            $display("FAIL async_reset_outputs: got p=%0d h=%0d mv=%b pe=%b de=%b lk=%b to=%b, expected all 0",
                     period, high_time, meas_valid, period_err, duty_err, locked, timeout);
        end
        clk_in = 1'b0;
        @(posedge clk);
        #3 rst = 1'b0;
        base = mq.size();
        @(posedge clk);
        #3;
        vec_cnt++;
        if (dut.state_q !== ARM) begin
            miss_cnt++;
            $display("FAIL reset_rearm_state: got %0d, expected %0d", dut.state_q, ARM);
        end
        drive_cycle(2, 3);
        vec_cnt++;
        if (mq.size() !== base) begin
            miss_cnt++;
            $display("FAIL reset_no_partial: got %0d measurements, expected 0", mq.size() - base);
        end
        drive_cycle(3, 2);
        got = (mq.size() > base) ? mq[base] : '0;
        vec_cnt++;
        if (mq.size() - base !== 1 || got !== mk(5, 2, 0, 0, 0)) begin
            miss_cnt++;
            $display("FAIL reset_first_full: got count=%0d %p, expected count=1 %p",
                     mq.size() - base, got, mk(5, 2, 0, 0, 0));
        end
    endtask

    task automatic test_en_drop();
        int base;
        meas_t got;
        meas_t exp_q[$];
        for (int k = 0; k < 4; k++) drive_cycle((k % 2 == 0) ? 2 : 3, (k % 2 == 0) ? 3 : 2);
        vec_cnt++;
        if (locked !== 1'b1) begin
            miss_cnt++;
            $display("FAIL en_drop_prelock: got %b, expected 1", locked);
        end
        en = 1'b0;
        @(posedge clk);
        #1;
        vec_cnt++;
        if ({locked, timeout} !== 2'b00 || dut.state_q !== IDLE) begin
            miss_cnt++;
            $display("FAIL en_drop_clear: got lk=%b to=%b state=%0d, expected lk=0 to=0 state=%0d",
                     locked, timeout, dut.state_q, IDLE);
        end
        repeat (2) @(posedge clk);
        #2 en = 1'b1;
        base = mq.size();
        for (int k = 0; k < 5; k++) drive_cycle((k % 2 == 0) ? 2 : 3, (k % 2 == 0) ? 3 : 2);
        exp_q = '{mk(5, 2, 0, 0, 0), mk(5, 3, 0, 0, 0), mk(5, 2, 0, 0, 0), mk(5, 3, 0, 0, 1)};
        vec_cnt++;
        if (mq.size() - base !== exp_q.size()) begin
            miss_cnt++;
            $display("FAIL relock_count: got %0d, expected %0d", mq.size() - base, exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (base + i < mq.size()) ? mq[base + i] : '0;
            vec_cnt++;
            if (got !== exp_q[i]) begin
                miss_cnt++;
                $display("FAIL relock_meas%0d: got %p, expected %p", i, got, exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lock_acquire();
        test_period_stretch();
        test_timeout();
        test_duty_error();
        test_reset_mid_meas();
        test_en_drop();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
